// File: rtl/c5_mem_responder_pkg.sv
// Shared constants, state/tag encodings and the IO command payload for the c5 memory responder.
package c5_mem_responder_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned ADDR_W   = 30;
  localparam int unsigned WE_W     = 4;
  localparam int unsigned REGION_W = 4;
  localparam int unsigned CNT_W    = 16;

  localparam logic [REGION_W-1:0] RAM_REGION   = 4'h0;
  localparam logic [REGION_W-1:0] IO_REGION    = 4'h2;
  localparam logic [WORD_W-1:0]   BUS_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_IO_WAIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_RAM  = 2'd1,
    TAG_IO   = 2'd2
  } tag_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WE_W-1:0]   we;
    logic [WORD_W-1:0] wdata;
  } io_cmd_t;

  // Region is byte-address bits [31:28], i.e. the top nibble of the word address.
  function automatic logic [REGION_W-1:0] region_of(input logic [ADDR_W-1:0] word_addr);
    return word_addr[ADDR_W-1 -: REGION_W];
  endfunction

endpackage

// File: rtl/c5_ram_bytewe.sv
// Byte-lane-enabled synchronous single-port RAM; a read returns the word as it was before a same-edge write.
module c5_ram_bytewe
  import c5_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 12
) (
  input  logic                 I_clk,
  input  logic                 I_en,
  input  logic [ADDR_BITS-1:0] I_addr,
  input  logic [WE_W-1:0]      I_we,
  input  logic [WORD_W-1:0]    I_wdata,
  output logic [WORD_W-1:0]    O_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [WORD_W-1:0] mem [DEPTH];

  // Non-blocking read and lane writes on the same edge give read-before-write.
  always_ff @(posedge I_clk) begin
    if (I_en) begin
      O_rdata <= mem[I_addr];
      for (int i = 0; i < int'(WE_W); i++) begin
        if (I_we[i]) begin
          mem[I_addr][8*i +: 8] <= I_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/c5_mem_responder.sv
// Plasma-bus target: zero-wait block RAM plus a handshaked IO port with timeout and bus-error reporting.
module c5_mem_responder
  import c5_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                I_clk,
  input  logic                I_rst,
  input  logic [ADDR_W-1:0]   I_address_next,
  input  logic [WE_W-1:0]     I_byte_we_next,
  input  logic [WORD_W-1:0]   I_data_w,
  output logic [WORD_W-1:0]   O_data_r,
  output logic                O_pause,
  output logic                O_io_req,
  output logic [ADDR_W-1:0]   O_io_addr,
  output logic [WE_W-1:0]     O_io_we,
  output logic [WORD_W-1:0]   O_io_wdata,
  input  logic                I_io_ack,
  input  logic [WORD_W-1:0]   I_io_rdata,
  output logic                O_bus_err
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state;
  tag_t              tag;
  io_cmd_t           io_cmd;
  logic [CNT_W-1:0]  wait_cnt;
  logic [WORD_W-1:0] io_data;
  logic [WORD_W-1:0] ram_rdata;
  logic              io_req_q;
  logic              bus_err_q;
  logic              ram_sel;
  logic              io_sel;

  // Bus inputs only matter while idle; the RAM is disabled during an IO wait.
  assign ram_sel = (state == ST_IDLE) && (region_of(I_address_next) == RAM_REGION);
  assign io_sel  = (state == ST_IDLE) && (region_of(I_address_next) == IO_REGION);

  c5_ram_bytewe #(
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .I_clk   (I_clk),
    .I_en    (ram_sel),
    .I_addr  (I_address_next[ADDR_BITS-1:0]),
    .I_we    (I_byte_we_next),
    .I_wdata (I_data_w),
    .O_rdata (ram_rdata)
  );

  // Access FSM, IO command/data registers and wait counter.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state     <= ST_IDLE;
      tag       <= TAG_NONE;
      io_cmd    <= '0;
      wait_cnt  <= '0;
      io_data   <= '0;
      io_req_q  <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (io_sel) begin
            io_cmd.addr  <= I_address_next;
            io_cmd.we    <= I_byte_we_next;
            io_cmd.wdata <= I_data_w;
            io_req_q     <= 1'b1;
            wait_cnt     <= '0;
            tag          <= TAG_IO;
            state        <= ST_IO_WAIT;
          end else if (ram_sel) begin
            tag <= TAG_RAM;
          end else begin
            tag <= TAG_NONE;
          end
        end
        ST_IO_WAIT: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          // An ack on the last permitted cycle beats the timeout.
          if (I_io_ack) begin
            io_data  <= I_io_rdata;
            io_req_q <= 1'b0;
            state    <= ST_IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            io_data   <= BUS_ERR_DATA;
            bus_err_q <= 1'b1;
            io_req_q  <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read data source follows the region of the last accepted access.
  always_comb begin
    O_data_r = '0;
    case (tag)
      TAG_RAM: O_data_r = ram_rdata;
      TAG_IO:  O_data_r = io_data;
      default: O_data_r = '0;
    endcase
  end

  assign O_pause    = (state == ST_IO_WAIT);
  assign O_io_req   = io_req_q;
  assign O_io_addr  = io_cmd.addr;
  assign O_io_we    = io_cmd.we;
  assign O_io_wdata = io_cmd.wdata;
  assign O_bus_err  = bus_err_q;

endmodule

// File: tb/tb_c5_mem_responder.sv
// Directed self-checking bench for c5_mem_responder: RAM vector table plus IO handshake, timeout and reset sequences.
module tb_c5_mem_responder;

  localparam int unsigned ADDR_BITS = 12;
  localparam int unsigned TIMEOUT   = 4;
  localparam logic [29:0] IDLE_ADDR = 30'h3C00_0000;

  logic        I_clk;
  logic        I_rst;
  logic [29:0] I_address_next;
  logic [3:0]  I_byte_we_next;
  logic [31:0] I_data_w;
  logic [31:0] O_data_r;
  logic        O_pause;
  logic        O_io_req;
  logic [29:0] O_io_addr;
  logic [3:0]  O_io_we;
  logic [31:0] O_io_wdata;
  logic        I_io_ack;
  logic [31:0] I_io_rdata;
  logic        O_bus_err;

  int n_cmp;
  int n_bad;

  c5_mem_responder #(
    .ADDR_BITS (ADDR_BITS),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .I_clk          (I_clk),
    .I_rst          (I_rst),
    .I_address_next (I_address_next),
    .I_byte_we_next (I_byte_we_next),
    .I_data_w       (I_data_w),
    .O_data_r       (O_data_r),
    .O_pause        (O_pause),
    .O_io_req       (O_io_req),
    .O_io_addr      (O_io_addr),
    .O_io_we        (O_io_we),
    .O_io_wdata     (O_io_wdata),
    .I_io_ack       (I_io_ack),
    .I_io_rdata     (I_io_rdata),
    .O_bus_err      (O_bus_err)
  );

  initial begin
    I_clk = 1'b0;
    forever #5 I_clk = ~I_clk;
  end

  typedef struct {
    logic [29:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge I_clk);
    #1;
  endtask

  task automatic drive(input logic [29:0] a, input logic [3:0] we, input logic [31:0] d);
    I_address_next = a;
    I_byte_we_next = we;
    I_data_w       = d;
  endtask

  // Counts pause cycles from the current cycle; acks in pause cycle ack_at (0 = never).
  task automatic measure_pause(input int ack_at, input logic [31:0] rd, output int n);
    n = 0;
    for (int k = 1; k <= 32; k++) begin
      if (!O_pause) break;
      n++;
      if (k == ack_at) begin
        I_io_ack   = 1'b1;
        I_io_rdata = rd;
      end
      step();
      I_io_ack = 1'b0;
    end
  endtask

  initial begin
    int n;
    n_cmp = 0;
    n_bad = 0;

    vecs[0]  = '{30'h0000_0000, 4'b1111, 32'h0BAD_F00D, 1'b0, 32'h0};
    vecs[1]  = '{30'h0000_0010, 4'b1111, 32'h1234_5678, 1'b0, 32'h0};
    vecs[2]  = '{30'h0000_0010, 4'b0010, 32'hAAAA_AAAA, 1'b1, 32'h1234_5678};
    vecs[3]  = '{30'h0000_0010, 4'b0000, 32'h0,         1'b1, 32'h1234_AA78};
    vecs[4]  = '{30'h0000_1010, 4'b0000, 32'h0,         1'b1, 32'h1234_AA78};
    vecs[5]  = '{30'h1000_0000, 4'b1111, 32'h5555_5555, 1'b1, 32'h0};
    vecs[6]  = '{30'h0000_0000, 4'b0000, 32'h0,         1'b1, 32'h0BAD_F00D};
    vecs[7]  = '{30'h0400_0010, 4'b0000, 32'h0,         1'b1, 32'h0};
    vecs[8]  = '{30'h0000_0021, 4'b1111, 32'h0,         1'b0, 32'h0};
    vecs[9]  = '{30'h0000_0021, 4'b1000, 32'h7777_7777, 1'b1, 32'h0};
    vecs[10] = '{30'h0000_0021, 4'b0000, 32'h0,         1'b1, 32'h7700_0000};
    vecs[11] = '{30'h0000_0010, 4'b0101, 32'h1111_1111, 1'b1, 32'h1234_AA78};
    vecs[12] = '{30'h0000_0010, 4'b0000, 32'h0,         1'b1, 32'h1211_AA11};

    I_rst      = 1'b1;
    I_io_ack   = 1'b0;
    I_io_rdata = '0;
    drive(IDLE_ADDR, 4'b0, 32'h0);

    // Reset values
    repeat (2) step();
    chk("rst_data_r", O_data_r, 32'h0);
    chk("rst_pause", 32'(O_pause), 32'h0);
    chk("rst_io_req", 32'(O_io_req), 32'h0);
    chk("rst_io_addr", 32'(O_io_addr), 32'h0);
    chk("rst_io_we", 32'(O_io_we), 32'h0);
    chk("rst_io_wdata", O_io_wdata, 32'h0);
    chk("rst_bus_err", 32'(O_bus_err), 32'h0);
    I_rst = 1'b0;
    step();

    // Back-to-back RAM / unmapped vectors
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].addr, vecs[i].we, vecs[i].wdata);
      step();
      if (vecs[i].chk) chk($sformatf("vec%0d_data", i), O_data_r, vecs[i].exp);
      chk($sformatf("vec%0d_pause", i), 32'(O_pause), 32'h0);
    end

    // IO read acked in the third pause cycle; a RAM write during the wait is ignored
    drive(30'h0800_0001, 4'b0000, 32'h0);
    step();
    chk("ior_req", 32'(O_io_req), 32'h1);
    chk("ior_addr", 32'(O_io_addr), 32'h0800_0001);
    chk("ior_we", 32'(O_io_we), 32'h0);
    drive(30'h0000_0010, 4'b1111, 32'hFFFF_FFFF);
    measure_pause(3, 32'hCAFE_F00D, n);
    chk("ior_pause_len", 32'(n), 32'd3);
    chk("ior_req_drop", 32'(O_io_req), 32'h0);
    chk("ior_data", O_data_r, 32'hCAFE_F00D);
    chk("ior_no_err", 32'(O_bus_err), 32'h0);
    drive(30'h0000_0010, 4'b0000, 32'h0);
    step();
    chk("ior_next_ram", O_data_r, 32'h1211_AA11);

    // IO write that is never acked
    drive(30'h0800_0010, 4'b1111, 32'h600D_CAFE);
    step();
    chk("tmo_we", 32'(O_io_we), 32'hF);
    chk("tmo_wdata", O_io_wdata, 32'h600D_CAFE);
    drive(IDLE_ADDR, 4'b0, 32'h0);
    measure_pause(0, 32'h0, n);
    chk("tmo_pause_len", 32'(n), 32'd4);
    chk("tmo_bus_err", 32'(O_bus_err), 32'h1);
    chk("tmo_data", O_data_r, 32'hDEAD_BEEF);
    chk("tmo_req_drop", 32'(O_io_req), 32'h0);
    step();
    chk("tmo_err_pulse", 32'(O_bus_err), 32'h0);

    // Ack on the final timeout cycle wins
    drive(30'h0800_0002, 4'b0000, 32'h0);
    step();
    drive(IDLE_ADDR, 4'b0, 32'h0);
    measure_pause(4, 32'h0C0F_FEE0, n);
    chk("lastack_pause_len", 32'(n), 32'd4);
    chk("lastack_no_err", 32'(O_bus_err), 32'h0);
    chk("lastack_data", O_data_r, 32'h0C0F_FEE0);
    step();
    chk("lastack_no_err2", 32'(O_bus_err), 32'h0);

    // Stale ack while idle
    I_io_ack   = 1'b1;
    I_io_rdata = 32'h1111_2222;
    step();
    I_io_ack = 1'b0;
    chk("stale_pause", 32'(O_pause), 32'h0);
    chk("stale_req", 32'(O_io_req), 32'h0);
    chk("stale_data", O_data_r, 32'h0);

    // RAM, RAM, IO, RAM back-to-back
    drive(30'h0000_0030, 4'b1111, 32'h1357_9BDF);
    step();
    chk("b2b_wr_pause", 32'(O_pause), 32'h0);
    drive(30'h0000_0021, 4'b0000, 32'h0);
    step();
    chk("b2b_rd_data", O_data_r, 32'h7700_0000);
    drive(30'h0800_0003, 4'b0000, 32'h0);
    step();
    chk("b2b_io_pause", 32'(O_pause), 32'h1);
    chk("b2b_io_olddata", O_data_r, 32'h0C0F_FEE0);
    drive(IDLE_ADDR, 4'b0, 32'h0);
    measure_pause(1, 32'h89AB_CDEF, n);
    chk("b2b_pause_len", 32'(n), 32'd1);
    chk("b2b_io_data", O_data_r, 32'h89AB_CDEF);
    drive(30'h0000_0030, 4'b0000, 32'h0);
    step();
    chk("b2b_ram_after_io", O_data_r, 32'h1357_9BDF);
    chk("b2b_ram_pause", 32'(O_pause), 32'h0);

    // Asynchronous reset in the middle of an IO wait
    drive(30'h0800_0004, 4'b0011, 32'hA5A5_5A5A);
    step();
    chk("mid_req_before", 32'(O_io_req), 32'h1);
    drive(IDLE_ADDR, 4'b0, 32'h0);
    #2;
    I_rst = 1'b1;
    #1;
    chk("mid_rst_pause", 32'(O_pause), 32'h0);
    chk("mid_rst_req", 32'(O_io_req), 32'h0);
    chk("mid_rst_data", O_data_r, 32'h0);
    chk("mid_rst_addr", 32'(O_io_addr), 32'h0);
    chk("mid_rst_we", 32'(O_io_we), 32'h0);
    chk("mid_rst_wdata", O_io_wdata, 32'h0);
    chk("mid_rst_err", 32'(O_bus_err), 32'h0);
    step();
    I_rst = 1'b0;
    step();
    chk("mid_rst_idle", 32'(O_pause), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
